// File: rtl/adder_pkg.sv
// Shared types for the bit-serial adder: FSM encoding and the counter width helper.
// No ports; imported by serial_adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One full-adder bit built from two half-adder cells and an OR of their carries.
// Ports: a, b, cin -> s, cout.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  // first half adder: a + b
  assign w_s0 = a ^ b;
  assign w_c0 = a & b;

  // second half adder: partial sum + cin
  assign s    = w_s0 ^ cin;
  assign w_c1 = w_s0 & cin;

  assign cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one bit per clock, LSB first; valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_sum_cat;

  full_adder_bit u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == LAST);
  // new bit enters at the MSB end, everything else moves down one
  assign w_sum_cat = {w_s, r_sum_sr};

  assign sum  = r_sum_sr;
  assign cout = r_carry;

  always_comb begin
    w_state_nxt = IDLE;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready    = 1'b1;
        w_state_nxt = w_accept ? RUN : IDLE;
      end
      RUN: begin
        w_state_nxt = w_last ? DONE : RUN;
      end
      DONE: begin
        out_valid   = 1'b1;
        w_state_nxt = out_ready ? IDLE : DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= w_sum_cat[WIDTH:1];
          r_carry  <= w_c;
          // wrap on the last step so the count stays below WIDTH
          r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 1, 8 and 13.
// Drives a shared operand bus; each instance has its own handshake.
module tb_serial_adder;

  logic        clk;
  logic        rst;
  logic [12:0] a_bus;
  logic [12:0] b_bus;
  logic        cin_bus;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  rdy;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [0:0]  s0;
  logic [7:0]  s1;
  logic [12:0] s2;

  int total;
  int bad;

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv[0]),
    .in_ready  (rdy[0]),
    .a         (a_bus[0:0]),
    .b         (b_bus[0:0]),
    .cin       (cin_bus),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .sum       (s0),
    .cout      (co[0])
  );

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv[1]),
    .in_ready  (rdy[1]),
    .a         (a_bus[7:0]),
    .b         (b_bus[7:0]),
    .cin       (cin_bus),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .sum       (s1),
    .cout      (co[1])
  );

  serial_adder #(.WIDTH(13)) u_w13 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv[2]),
    .in_ready  (rdy[2]),
    .a         (a_bus),
    .b         (b_bus),
    .cin       (cin_bus),
    .out_valid (ov[2]),
    .out_ready (ordy[2]),
    .sum       (s2),
    .cout      (co[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int sel);
    case (sel)
      0:       return 1;
      1:       return 8;
      default: return 13;
    endcase
  endfunction

  function automatic logic [12:0] get_sum(input int sel);
    case (sel)
      0:       return {12'd0, s0};
      1:       return {5'd0, s1};
      default: return s2;
    endcase
  endfunction

  // One operation on instance sel: accept, count latency, optional
  // backpressure for hold cycles, then handshake and check result.
  task automatic do_op(input int sel,
                       input logic [12:0] av,
                       input logic [12:0] bv,
                       input logic ci,
                       input int gap,
                       input int hold,
                       input bit glitch);
    int          w;
    int          n;
    logic [13:0] m;
    logic [13:0] e;
    logic [12:0] sv;
    logic        cv;
    bit          rdy_bad;
    bit          hold_bad;
    w = wid(sel);
    m = (14'd1 << w) - 14'd1;
    e = (m & {1'b0, av}) + (m & {1'b0, bv}) + {13'd0, ci};
    rdy_bad  = 1'b0;
    hold_bad = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    a_bus   = av;
    b_bus   = bv;
    cin_bus = ci;
    iv[sel] = 1'b1;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
    // operands must be ignored once accepted
    a_bus   = ~av;
    b_bus   = ~bv;
    cin_bus = ~ci;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (ov[sel]) break;
      if (rdy[sel]) rdy_bad = 1'b1;
      if (glitch) iv[sel] = (n == 1);
      @(posedge clk);
    end
    iv[sel] = 1'b0;
    chk("latency", n, w);
    chk("ready_low_run", {31'd0, rdy_bad}, 0);
    sv = get_sum(sel);
    cv = co[sel];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!ov[sel] || rdy[sel]) hold_bad = 1'b1;
      if (get_sum(sel) !== sv || co[sel] !== cv) hold_bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", {31'd0, hold_bad}, 0);
    chk("sum", {19'd0, sv}, {19'd0, e[12:0] & m[12:0]});
    chk("cout", {31'd0, cv}, {31'd0, e[w]});
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
    @(negedge clk);
    chk("ready_after", {30'd0, rdy[sel], ov[sel]}, 32'd2);
  endtask

  initial begin
    bit ov_seen;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    iv      = '0;
    ordy    = '0;
    a_bus   = '0;
    b_bus   = '0;
    cin_bus = 1'b0;

    // reset state for every width
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_ready", {31'd0, rdy[s]}, 1);
      chk("rst_valid", {31'd0, ov[s]}, 0);
      chk("rst_sum", {19'd0, get_sum(s)}, 0);
      chk("rst_cout", {31'd0, co[s]}, 0);
    end
    rst = 1'b0;

    // carry ripples all the way out
    do_op(1, 13'h0FF, 13'h001, 1'b0, 1, 0, 1'b0);
    // cin used; stray in_valid during RUN ignored
    do_op(1, 13'h05A, 13'h033, 1'b1, 0, 0, 1'b1);
    // backpressure for 5 cycles in DONE
    do_op(1, 13'h0C3, 13'h07E, 1'b1, 2, 5, 1'b0);

    // reset on the 4th RUN cycle
    @(posedge clk);
    #1;
    a_bus   = 13'h012;
    b_bus   = 13'h034;
    cin_bus = 1'b0;
    iv[1]   = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b1;
    iv[1] = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    iv[1] = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, rdy[1]}, 1);
    ov_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[1] || !rdy[1]) ov_seen = 1'b1;
    end
    chk("mid_rst_quiet", {31'd0, ov_seen}, 0);
    do_op(1, 13'h080, 13'h080, 1'b0, 0, 0, 1'b0);

    // width 1 exhaustive
    for (int v = 0; v < 8; v++) begin
      do_op(0, {12'd0, v[0]}, {12'd0, v[1]}, v[2], 0, v % 2, 1'b0);
    end

    // width 13 corners
    do_op(2, 13'h1FFF, 13'h0000, 1'b1, 0, 1, 1'b0);
    do_op(2, 13'h1FFF, 13'h1FFF, 1'b1, 0, 0, 1'b0);

    // random mix across widths
    for (int i = 0; i < 300; i++) begin
      do_op($urandom_range(0, 2), 13'($urandom), 13'($urandom),
            1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
